// File: rtl/sccb_rw_master.sv
// SCCB register read/write master: accepts one 17-bit command at a time, bit-bangs
// the SIOC/SIOD transaction to the sensor and returns an 18-bit response with a pulse.
module sccb_rw_master #(
    parameter int unsigned CLK_DIV = 125,
    parameter logic [7:0]  DEV_ID  = 8'h42
) (
    input  logic        ACLK,
    input  logic        rst_n,
    input  logic [16:0] rw_cmd,
    input  logic        rw_cmd_valid,
    output logic [17:0] rw_resp,
    output logic        rw_resp_valid,
    output logic        busy,
    output logic        sioc,
    output logic        siod_oe,
    input  logic        siod_i
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [1:0]       q, q_nxt;
    logic [3:0]       bitc, bitc_nxt;
    logic [1:0]       bytec, bytec_nxt;
    logic             phase, phase_nxt;
    logic [16:0]      cmd, cmd_nxt;
    logic [7:0]       rdata, rdata_nxt;
    logic             nack, nack_nxt;
    logic [17:0]      resp_nxt;
    logic             resp_valid_nxt, busy_nxt, sioc_nxt, siod_oe_nxt;

    logic       is_write, rx_byte, last_byte, q_end, sample;
    logic [7:0] tx_byte;

    assign is_write  = cmd[16];
    assign q_end     = (div == DIV_LAST);
    assign sample    = (state == BIT) && (q == 2'd2) && q_end;
    // Only the second byte of a read's second phase is driven by the sensor.
    assign rx_byte   = phase && (bytec == 2'd1);
    assign last_byte = is_write ? (bytec == 2'd2) : (bytec == 2'd1);

    always_comb begin
        case (bytec)
            2'd0:    tx_byte = phase ? (DEV_ID | 8'h01) : DEV_ID;
            2'd1:    tx_byte = cmd[15:8];
            default: tx_byte = cmd[7:0];
        endcase
    end

    always_comb begin
        state_nxt      = state;
        div_nxt        = div;
        q_nxt          = q;
        bitc_nxt       = bitc;
        bytec_nxt      = bytec;
        phase_nxt      = phase;
        cmd_nxt        = cmd;
        rdata_nxt      = rdata;
        nack_nxt       = nack;
        resp_nxt       = rw_resp;
        resp_valid_nxt = 1'b0;
        busy_nxt       = busy;

        if (state != IDLE)
            div_nxt = q_end ? '0 : div + 1'b1;

        if (sample) begin
            if (bitc == 4'd8) begin
                if (!rx_byte)
                    nack_nxt = nack | siod_i;
            end else if (rx_byte) begin
                rdata_nxt = {rdata[6:0], siod_i};
            end
        end

        case (state)
            IDLE: begin
                if (rw_cmd_valid) begin
                    state_nxt = START;
                    cmd_nxt   = rw_cmd;
                    busy_nxt  = 1'b1;
                    div_nxt   = '0;
                    q_nxt     = 2'd0;
                    bitc_nxt  = 4'd0;
                    bytec_nxt = 2'd0;
                    phase_nxt = 1'b0;
                    nack_nxt  = 1'b0;
                    rdata_nxt = 8'd0;
                end
            end
            START: begin
                if (q_end) begin
                    if (q == 2'd1) begin
                        state_nxt = BIT;
                        q_nxt     = 2'd0;
                        bitc_nxt  = 4'd0;
                    end else begin
                        q_nxt = q + 2'd1;
                    end
                end
            end
            BIT: begin
                if (q_end) begin
                    q_nxt = q + 2'd1;
                    if (q == 2'd3) begin
                        if (bitc != 4'd8) begin
                            bitc_nxt = bitc + 4'd1;
                        end else begin
                            bitc_nxt = 4'd0;
                            if (last_byte) begin
                                state_nxt = STOP;
                                bytec_nxt = 2'd0;
                            end else begin
                                bytec_nxt = bytec + 2'd1;
                            end
                        end
                    end
                end
            end
            STOP: begin
                if (q_end) begin
                    q_nxt = q + 2'd1;
                    if (q == 2'd3) begin
                        if (!is_write && !phase) begin
                            phase_nxt = 1'b1;
                            state_nxt = START;
                        end else begin
                            state_nxt      = IDLE;
                            busy_nxt       = 1'b0;
                            resp_valid_nxt = 1'b1;
                            resp_nxt       = {nack, cmd[16:8], is_write ? cmd[7:0] : rdata};
                        end
                    end
                end
            end
        endcase

        // Pad outputs are registered from the current state, so they trail it by one cycle.
        sioc_nxt    = 1'b1;
        siod_oe_nxt = 1'b0;
        case (state)
            IDLE: begin
                sioc_nxt    = 1'b1;
                siod_oe_nxt = 1'b0;
            end
            START: begin
                sioc_nxt    = 1'b1;
                siod_oe_nxt = (q == 2'd1);
            end
            BIT: begin
                sioc_nxt = (q == 2'd1) || (q == 2'd2);
                // Hold SIOD through the first q0 cycle so it never moves on the SIOC falling edge.
                if (q == 2'd0 && div == '0)
                    siod_oe_nxt = siod_oe;
                else
                    siod_oe_nxt = (bitc != 4'd8) && !rx_byte && !tx_byte[~bitc[2:0]];
            end
            STOP: begin
                sioc_nxt    = (q != 2'd0);
                siod_oe_nxt = (q == 2'd0) || (q == 2'd1);
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            div           <= '0;
            q             <= 2'd0;
            bitc          <= 4'd0;
            bytec         <= 2'd0;
            phase         <= 1'b0;
            cmd           <= 17'd0;
            rdata         <= 8'd0;
            nack          <= 1'b0;
            rw_resp       <= 18'd0;
            rw_resp_valid <= 1'b0;
            busy          <= 1'b0;
            sioc          <= 1'b1;
            siod_oe       <= 1'b0;
        end else begin
            state         <= state_nxt;
            div           <= div_nxt;
            q             <= q_nxt;
            bitc          <= bitc_nxt;
            bytec         <= bytec_nxt;
            phase         <= phase_nxt;
            cmd           <= cmd_nxt;
            rdata         <= rdata_nxt;
            nack          <= nack_nxt;
            rw_resp       <= resp_nxt;
            rw_resp_valid <= resp_valid_nxt;
            busy          <= busy_nxt;
            sioc          <= sioc_nxt;
            siod_oe       <= siod_oe_nxt;
        end
    end

endmodule

// File: tb/tb_sccb_rw_master.sv
// Scoreboard bench for sccb_rw_master with a behavioural SCCB slave on the bus.
`timescale 1ns/1ps
module tb_sccb_rw_master;

    localparam int S_T = 256, P_T = 257, NA_T = 258, AK_T = 259;

    logic        ACLK, rst_n;
    logic [16:0] rw_cmd;
    logic        rw_cmd_valid;
    logic [17:0] rw_resp;
    logic        rw_resp_valid, busy, sioc, siod_oe, siod_i;
    logic        pull;

    assign siod_i = !(siod_oe || pull);

    sccb_rw_master #(.CLK_DIV(4), .DEV_ID(8'h42)) dut (
        .ACLK(ACLK), .rst_n(rst_n), .rw_cmd(rw_cmd), .rw_cmd_valid(rw_cmd_valid),
        .rw_resp(rw_resp), .rw_resp_valid(rw_resp_valid), .busy(busy),
        .sioc(sioc), .siod_oe(siod_oe), .siod_i(siod_i)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0, n_resp = 0;
    logic [17:0] exp_resp[$];
    int exp_t0[$], exp_lat[$];
    int bus_log[$], exp_bus[$];
    int nack_byte = -1;
    logic [7:0] rd_val = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SCCB slave: detects START/STOP, shifts bytes on SIOC rise, drives ack/data after SIOC fall.
    initial begin
        logic c, d, in_rx, prev_c, prev_d, s_rd;
        logic [7:0] sh;
        int s_bit, s_byte;
        prev_c = 1; prev_d = 1; s_rd = 0; sh = 0; s_bit = 0; s_byte = 0; pull = 0;
        forever begin
            @(negedge ACLK);
            c = sioc; d = siod_i;
            if (!rst_n) begin
                prev_c = 1; prev_d = 1; s_rd = 0; s_bit = 0; s_byte = 0; pull = 0;
            end else begin
                in_rx = s_rd && (s_byte == 1);
                if (c && prev_c && prev_d && !d) begin
                    bus_log.push_back(S_T); s_bit = 0; s_byte = 0; s_rd = 0;
                end else if (c && prev_c && !prev_d && d) begin
                    bus_log.push_back(P_T); pull = 0;
                end else if (c && !prev_c) begin
                    if (s_bit < 8) sh = {sh[6:0], d};
                    else if (s_bit == 8 && in_rx) bus_log.push_back(d ? NA_T : AK_T);
                    s_bit++;
                    if (s_bit == 8) begin
                        bus_log.push_back(int'(sh));
                        if (s_byte == 0) s_rd = sh[0];
                    end
                end else if (!c && prev_c) begin
                    if (s_bit == 9) begin s_bit = 0; s_byte++; end
                    in_rx = s_rd && (s_byte == 1);
                    if (s_bit == 8) pull = !in_rx && (s_byte != nack_byte);
                    else if (in_rx && s_bit < 8) pull = !rd_val[7 - s_bit];
                    else pull = 0;
                end
                prev_c = c; prev_d = d;
            end
        end
    end

    // Monitor: every response pulse pops one expectation.
    initial begin
        logic [17:0] e;
        int t0, lat;
        forever begin
            @(negedge ACLK);
            if (rst_n && rw_resp_valid) begin
                n_resp++;
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", 32'(rw_resp), 32'h3ffff);
                end else begin
                    e = exp_resp.pop_front(); t0 = exp_t0.pop_front(); lat = exp_lat.pop_front();
                    check("resp", 32'(rw_resp), 32'(e));
                    check("latency", cyc - t0, lat);
                    check("busy_at_resp", 32'(busy), 0);
                end
            end
        end
    end

    task automatic issue(input logic [16:0] cmd, input logic [17:0] exp, input int lat, input int hold);
        exp_resp.push_back(exp); exp_t0.push_back(cyc); exp_lat.push_back(lat);
        rw_cmd = cmd; rw_cmd_valid = 1;
        repeat (hold) @(negedge ACLK);
        rw_cmd_valid = 0;
    endtask

    task automatic drive(input logic [16:0] cmd, input int hold);
        rw_cmd = cmd; rw_cmd_valid = 1;
        repeat (hold) @(negedge ACLK);
        rw_cmd_valid = 0;
    endtask

    task automatic wait_resp(input string nm, output int busy_low);
        int n;
        busy_low = 0; n = 0;
        do begin
            @(negedge ACLK); n++;
            if (!busy && !rw_resp_valid) busy_low++;
        end while (!rw_resp_valid && n < 2000);
        check({nm, "_resp_arrived"}, 32'(rw_resp_valid), 1);
    endtask

    task automatic check_bus(input string nm, input int mark);
        int bad;
        bad = -1;
        if (bus_log.size() - mark != exp_bus.size()) bad = 999;
        else for (int i = 0; i < exp_bus.size(); i++)
            if (bad < 0 && bus_log[mark + i] != exp_bus[i]) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: bus events %0d (first bad index %0d) expected %0d events",
                     nm, bus_log.size() - mark, bad, exp_bus.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mark, bl, r0;
        rst_n = 0; rw_cmd = 0; rw_cmd_valid = 0;
        repeat (3) @(negedge ACLK);
        check("rst_sioc", 32'(sioc), 1);
        check("rst_siod_oe", 32'(siod_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_resp", 32'(rw_resp), 0);
        check("rst_resp_valid", 32'(rw_resp_valid), 0);
        rst_n = 1;
        repeat (3) @(negedge ACLK);

        // Write 0x80 to 0x12
        mark = bus_log.size();
        issue(17'h11280, 18'h11280, 457, 1);
        wait_resp("write", bl);
        exp_bus = '{S_T, 'h42, 'h12, 'h80, P_T};
        check_bus("write_bus", mark);
        repeat (5) @(negedge ACLK);

        // Read 0x0A, sensor returns 0x76
        rd_val = 8'h76; mark = bus_log.size();
        issue(17'h00A00, 18'h00A76, 625, 1);
        wait_resp("read", bl);
        exp_bus = '{S_T, 'h42, 'h0A, P_T, S_T, 'h43, 'h76, NA_T, P_T};
        check_bus("read_bus", mark);
        repeat (5) @(negedge ACLK);

        // Sub-address NACKed: transaction still runs to the end
        nack_byte = 1; mark = bus_log.size();
        issue(17'h13A04, 18'h33A04, 457, 1);
        wait_resp("nack", bl);
        exp_bus = '{S_T, 'h42, 'h3A, 'h04, P_T};
        check_bus("nack_bus", mark);
        nack_byte = -1;
        repeat (5) @(negedge ACLK);

        // Valid held 3 cycles, then a stray command mid-transaction
        r0 = n_resp;
        issue(17'h10155, 18'h10155, 457, 3);
        repeat (100) @(negedge ACLK);
        drive(17'h1FFFF, 1);
        wait_resp("hold", bl);
        check("hold_busy_low_cycles", bl, 0);
        repeat (600) @(negedge ACLK);
        check("hold_resp_count", n_resp - r0, 1);

        // Reset during the second byte, then a clean write
        drive(17'h16DE1, 1);
        repeat (200) @(negedge ACLK);
        rst_n = 0;
        #1;
        check("midrst_sioc", 32'(sioc), 1);
        check("midrst_siod_oe", 32'(siod_oe), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (3) @(negedge ACLK);
        rst_n = 1;
        repeat (2) @(negedge ACLK);
        mark = bus_log.size();
        issue(17'h15AC3, 18'h15AC3, 457, 1);
        wait_resp("postrst", bl);
        exp_bus = '{S_T, 'h42, 'h5A, 'hC3, P_T};
        check_bus("postrst_bus", mark);
        repeat (5) @(negedge ACLK);

        // Back-to-back: next command presented in the response cycle
        rd_val = 8'h5A; mark = bus_log.size();
        issue(17'h00B00, 18'h00B5A, 625, 1);
        wait_resp("b2b_first", bl);
        issue(17'h10C33, 18'h10C33, 457, 1);
        check("b2b_accepted", 32'(busy), 1);
        wait_resp("b2b_second", bl);
        exp_bus = '{S_T, 'h42, 'h0B, P_T, S_T, 'h43, 'h5A, NA_T, P_T, S_T, 'h42, 'h0C, 'h33, P_T};
        check_bus("b2b_bus", mark);

        repeat (20) @(negedge ACLK);
        check("scoreboard_empty", exp_resp.size(), 0);
        check("resp_total", n_resp, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
